cmd_parser: RTL and testbench
=============================

Name: cmd_parser

Overview:
- Upstream stage of the control block. Assembles the 5-byte Protocol-1 command field (C0..C4) from the received-frame byte stream.
- Presents one command per frame as cmd_addr / cmd_data / cmd_ptt / cmd_requires_resp with a single-cycle cmd_rqst strobe.
- Enforces byte-gap framing and a PTT safety watchdog, so a stalled host can never leave the transmitter keyed.

Parameters:
- GAP_CYCLES, 16: maximum clk cycles allowed between consecutive bytes of one command before it is discarded.
- PTT_TIMEOUT, 250000: clk cycles without a completed command before cmd_ptt is forced low (100 ms at 2.5 MHz).
- CNT_W, 16: width of the completed-command counter.

Ports:
- clk  in  1  block clock (2.5 MHz domain shared with control).
- rst  in  1  asynchronous active-high reset.
- rx_data  in  8  command byte.
- rx_valid  in  1  rx_data valid this cycle.
- rx_sof  in  1  qualifies rx_data as C0; meaningful only with rx_valid.
- rx_abort  in  1  upstream frame error; discard any partial command.
- cmd_addr  out  6  command address, C0[6:1].
- cmd_data  out  32  {C1,C2,C3,C4}, C1 in bits 31:24.
- cmd_rqst  out  1  one-cycle strobe; command fields valid.
- cmd_requires_resp  out  1  C0[7].
- cmd_ptt  out  1  C0[0], gated by the watchdog.
- cmd_err  out  1  one-cycle pulse on any discarded partial command.
- ptt_wdog  out  1  high while the watchdog is forcing PTT off.
- cmd_count  out  CNT_W  completed commands, wraps.

Behaviour:
- Reset is asynchronous, active-high, and fixed as stated under Already decided. While rst is high and after its release, all outputs are 0 and the FSM is in IDLE.
- FSM states: IDLE, GET1, GET2, GET3, GET4, EMIT.

State transitions:
- IDLE: rx_valid & rx_sof latches C0 into a shadow register and goes to GET1. rx_valid without rx_sof is ignored, with no error.
- GETn (n=1..4): rx_valid & ~rx_sof stores byte Cn into shadow data[39-8n -: 8]. GET1..GET3 then advance; GET4 goes to EMIT.
- GETn: rx_valid & rx_sof restarts the command (new C0, go to GET1) and pulses cmd_err.
- EMIT: copy the shadow registers into the output registers, pulse cmd_rqst for exactly one cycle, increment cmd_count, and return to IDLE. In EMIT, rx_valid & rx_sof is accepted as a new C0 (go to GET1), so back-to-back commands lose no bytes.

Output latency:
- cmd_rqst rises on the clock edge after the edge that captures C4 (1-cycle latency).
- cmd_addr, cmd_data and cmd_requires_resp change only on that edge and hold until the next emit.
- Bytes arriving with rx_valid low are never sampled.

Gap timer:
- Counts cycles in GET1..GET4 with no rx_valid and clears on each accepted byte.
- When it reaches GAP_CYCLES: return to IDLE, pulse cmd_err, leave the outputs unchanged.

rx_abort:
- In GET1..GET4: return to IDLE and pulse cmd_err.
- In IDLE or EMIT: no effect, except that it blocks a same-cycle sof acceptance. The EMIT strobe still occurs.
- rx_abort has priority over rx_valid in the same cycle.

PTT watchdog:
- The watchdog counter clears on every cmd_rqst and otherwise increments, saturating at PTT_TIMEOUT.
- At saturation: ptt_wdog=1 and cmd_ptt=0. The latched C0[0] is retained.
- ptt_wdog clears on the next cmd_rqst, and cmd_ptt then takes the new C0[0] in the same cycle.
- Out of reset the counter starts at 0.

Other rules:
- cmd_err and cmd_rqst are never asserted in the same cycle.
- cmd_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Command emit: send sof+0x93, then 0x12, 0x34, 0x56, 0x78 on consecutive cycles. Expect cmd_rqst for 1 cycle, 1 cycle after the 0x78 edge, with cmd_addr=0x09, cmd_data=0x12345678, cmd_requires_resp=1, cmd_ptt=1, cmd_count=1.
- Stream gaps and back-to-back frames:
  - Bytes separated by 5 idle cycles (GAP_CYCLES=16) give a normal emit.
  - A second sof byte presented in the EMIT cycle gives a second cmd_rqst exactly 5 cycles after the first.
  - Bytes with rx_valid low are ignored.
- Error paths:
  - sof, C1, C2, then 20 idle cycles: cmd_err pulses once on the gap expiry, no cmd_rqst, and the outputs keep their previous values.
  - sof, C1, then a second sof: cmd_err pulses, and the following 4 bytes emit using the second C0.
  - rx_abort during GET3: cmd_err pulses, no emit.
- Watchdog: PTT_TIMEOUT=100, send a command with C0=0x01.
  - cmd_ptt=1 until cycle 100 after cmd_rqst, then cmd_ptt=0 and ptt_wdog=1.
  - The next command with C0=0x01 restores cmd_ptt=1 and ptt_wdog=0 on its cmd_rqst edge.
- Reset and wrap:
  - Assert rst asynchronously mid-GET2: all outputs go to 0 immediately, and after release the next sof is accepted.
  - With CNT_W=4, 16 commands wrap cmd_count to 0.

Source files
------------

// File: rtl/cmd_parser.sv
// cmd_parser: assembles the 5-byte command field (C0..C4) from the received
// byte stream and presents it with a one-cycle cmd_rqst strobe.
//
// Ports:
//   clk, rst           block clock, asynchronous active-high reset
//   rx_data/rx_valid   incoming byte and its qualifier
//   rx_sof             marks rx_data as C0 (only with rx_valid)
//   rx_abort           upstream frame error, drops a partial command
//   cmd_addr/cmd_data  decoded address C0[6:1] and {C1,C2,C3,C4}
//   cmd_rqst           one-cycle strobe, command fields valid
//   cmd_requires_resp  C0[7]
//   cmd_ptt            C0[0], forced low while the watchdog has expired
//   cmd_err            one-cycle pulse on a discarded partial command
//   ptt_wdog           high while the watchdog is forcing PTT off
//   cmd_count          completed commands, wraps
module cmd_parser #(
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned PTT_TIMEOUT = 250000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_sof,
    input  logic             rx_abort,
    output logic [5:0]       cmd_addr,
    output logic [31:0]      cmd_data,
    output logic             cmd_rqst,
    output logic             cmd_requires_resp,
    output logic             cmd_ptt,
    output logic             cmd_err,
    output logic             ptt_wdog,
    output logic [CNT_W-1:0] cmd_count
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned WD_W  = $clog2(PTT_TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(PTT_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, GET1, GET2, GET3, GET4, EMIT
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         c0_q, c0_d;
    logic [31:0]        sh_q, sh_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [5:0]         addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               resp_q, resp_d;
    logic               ptt_lat_q, ptt_lat_d;
    logic               ptt_q, ptt_d;
    logic               wdog_q, wdog_d;
    logic               rqst_q, rqst_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sof_ok;
    logic               byte_ok;
    logic [GAP_W-1:0]   gap_inc;

    // Abort outranks any byte presented in the same cycle.
    assign sof_ok  = rx_valid & rx_sof & ~rx_abort;
    assign byte_ok = rx_valid & ~rx_sof & ~rx_abort;
    assign gap_inc = gap_q + GAP_W'(1);

    always_comb begin
        state_d   = state_q;
        c0_d      = c0_q;
        sh_d      = sh_q;
        gap_d     = gap_q;
        addr_d    = addr_q;
        data_d    = data_q;
        resp_d    = resp_q;
        ptt_lat_d = ptt_lat_q;
        cnt_d     = cnt_q;
        rqst_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sof_ok) begin
                    c0_d    = rx_data;
                    gap_d   = '0;
                    state_d = GET1;
                end
            end
            GET1, GET2, GET3, GET4: begin
                if (rx_abort) begin
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = IDLE;
                end else if (sof_ok) begin
                    c0_d    = rx_data;
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = GET1;
                end else if (byte_ok) begin
                    // Shifting in four bytes lands C1 in [31:24].
                    sh_d  = {sh_q[23:0], rx_data};
                    gap_d = '0;
                    unique case (state_q)
                        GET1:    state_d = GET2;
                        GET2:    state_d = GET3;
                        GET3:    state_d = GET4;
                        default: state_d = EMIT;
                    endcase
                end else if (gap_inc == GAP_MAX) begin
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_inc;
                end
            end
            EMIT: begin
                rqst_d    = 1'b1;
                addr_d    = c0_q[6:1];
                resp_d    = c0_q[7];
                ptt_lat_d = c0_q[0];
                data_d    = sh_q;
                cnt_d     = cnt_q + CNT_W'(1);
                state_d   = IDLE;
                if (sof_ok) begin
                    c0_d    = rx_data;
                    gap_d   = '0;
                    state_d = GET1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog restarts on every emit, else saturates at WD_MAX.
        wd_d = wd_q;
        if (state_q == EMIT) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WD_W'(1);
        end
        wdog_d = (wd_d == WD_MAX);
        ptt_d  = ptt_lat_d & ~wdog_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            c0_q      <= '0;
            sh_q      <= '0;
            gap_q     <= '0;
            wd_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            resp_q    <= 1'b0;
            ptt_lat_q <= 1'b0;
            ptt_q     <= 1'b0;
            wdog_q    <= 1'b0;
            rqst_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            c0_q      <= c0_d;
            sh_q      <= sh_d;
            gap_q     <= gap_d;
            wd_q      <= wd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            resp_q    <= resp_d;
            ptt_lat_q <= ptt_lat_d;
            ptt_q     <= ptt_d;
            wdog_q    <= wdog_d;
            rqst_q    <= rqst_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cmd_addr          = addr_q;
    assign cmd_data          = data_q;
    assign cmd_rqst          = rqst_q;
    assign cmd_requires_resp = resp_q;
    assign cmd_ptt           = ptt_q;
    assign cmd_err           = err_q;
    assign ptt_wdog          = wdog_q;
    assign cmd_count         = cnt_q;

endmodule

// File: tb/tb_cmd_parser.sv
// tb_cmd_parser: directed stimulus for cmd_parser with a queue-based
// scoreboard; a negedge monitor pops one expectation per rqst/err pulse.
module tb_cmd_parser;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_abort;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_rqst;
    logic        cmd_requires_resp;
    logic        cmd_ptt;
    logic        cmd_err;
    logic        ptt_wdog;
    logic [3:0]  cmd_count;

    cmd_parser #(
        .GAP_CYCLES (16),
        .PTT_TIMEOUT(100),
        .CNT_W      (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_sof           (rx_sof),
        .rx_abort         (rx_abort),
        .cmd_addr         (cmd_addr),
        .cmd_data         (cmd_data),
        .cmd_rqst         (cmd_rqst),
        .cmd_requires_resp(cmd_requires_resp),
        .cmd_ptt          (cmd_ptt),
        .cmd_err          (cmd_err),
        .ptt_wdog         (ptt_wdog),
        .cmd_count        (cmd_count)
    );

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [5:0]  addr;
        logic [31:0] data;
        logic        resp;
        logic        ptt;
        logic [3:0]  cnt;
    } exp_t;

    exp_t        q[$];
    int          checks;
    int          failures;
    int          cyc;
    logic [3:0]  exp_cnt;
    logic [5:0]  last_addr;
    logic [31:0] last_data;
    logic        last_resp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    // Monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (cmd_rqst && cmd_err) begin
                chk("rqst_err_overlap", 1, 0);
            end
            if (cmd_rqst || cmd_err) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event rqst=%0b err=%0b cyc=%0d",
                             cmd_rqst, cmd_err, cyc);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", {cmd_rqst, cmd_err},
                        {~e.is_err, e.is_err});
                    chk("event_cycle", cyc, e.cyc);
                    if (!e.is_err) begin
                        chk("cmd_addr", cmd_addr, e.addr);
                        chk("cmd_data", cmd_data, e.data);
                        chk("cmd_resp", cmd_requires_resp, e.resp);
                        chk("cmd_ptt", cmd_ptt, e.ptt);
                        chk("ptt_wdog_at_rqst", ptt_wdog, 0);
                        chk("cmd_count", cmd_count, e.cnt);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        rx_valid = 1'b0;
        rx_sof   = 1'b1;
        rx_data  = 8'hA5;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rx_sof = 1'b0;
    endtask

    task automatic put(input logic [7:0] d, input logic sof);
        rx_valid = 1'b1;
        rx_sof   = sof;
        rx_data  = d;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_data  = 8'h5A;
    endtask

    task automatic push_rqst(input logic [7:0] c0, input logic [31:0] d,
                             input int c);
        exp_t e;
        exp_cnt   = exp_cnt + 4'd1;
        e.is_err  = 1'b0;
        e.cyc     = c;
        e.addr    = c0[6:1];
        e.data    = d;
        e.resp    = c0[7];
        e.ptt     = c0[0];
        e.cnt     = exp_cnt;
        last_addr = e.addr;
        last_data = d;
        last_resp = e.resp;
        q.push_back(e);
    endtask

    task automatic push_err(input int c);
        exp_t e;
        e.is_err = 1'b1;
        e.cyc    = c;
        e.addr   = '0;
        e.data   = '0;
        e.resp   = 1'b0;
        e.ptt    = 1'b0;
        e.cnt    = '0;
        q.push_back(e);
    endtask

    // C4 is captured on the last put; strobe follows one edge later.
    task automatic send_cmd(input logic [7:0] c0, input logic [31:0] d,
                            input int gap);
        put(c0, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            if (gap > 0) idle(gap);
            put(d[i*8 +: 8], 1'b0);
        end
        push_rqst(c0, d, cyc + 1);
    endtask

    initial begin
        int cap;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        exp_cnt  = '0;
        last_addr = '0;
        last_data = '0;
        last_resp = 1'b0;
        rst      = 1'b1;
        rx_data  = '0;
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {cmd_addr, cmd_data, cmd_rqst, cmd_requires_resp,
             cmd_ptt, cmd_err, ptt_wdog, cmd_count}, 0);
        rst = 1'b0;
        idle(2);
        chk("post_reset_outputs",
            {cmd_addr, cmd_data, cmd_rqst, cmd_requires_resp,
             cmd_ptt, cmd_err, ptt_wdog, cmd_count}, 0);

        // Non-sof byte in IDLE is ignored silently.
        put(8'h77, 1'b0);
        idle(2);

        // Basic emit: addr 0x09, resp 1, ptt 1, count 1.
        send_cmd(8'h93, 32'h12345678, 0);
        idle(3);
        chk("emit1_fields",
            {cmd_addr, cmd_data, cmd_requires_resp, cmd_ptt, cmd_count},
            {6'h09, 32'h12345678, 1'b1, 1'b1, 4'd1});

        // Gapped bytes (5 idle cycles, with invalid data around).
        send_cmd(8'h2A, 32'hA1B2C3D4, 5);
        // Back-to-back: second sof lands in the EMIT cycle.
        send_cmd(8'h45, 32'h0BADF00D, 0);
        idle(4);

        // Gap expiry after C2: error 16 edges later, outputs held.
        put(8'hFF, 1'b1);
        put(8'h11, 1'b0);
        put(8'h22, 1'b0);
        cap = cyc;
        push_err(cap + 16);
        idle(20);
        chk("hold_after_gap",
            {cmd_addr, cmd_data, cmd_requires_resp, cmd_count},
            {last_addr, last_data, last_resp, exp_cnt});

        // Restart by a second sof inside GET2.
        put(8'h81, 1'b1);
        put(8'h99, 1'b0);
        put(8'h3C, 1'b1);
        push_err(cyc);
        put(8'hDE, 1'b0);
        put(8'hAD, 1'b0);
        put(8'hBE, 1'b0);
        put(8'hEF, 1'b0);
        push_rqst(8'h3C, 32'hDEADBEEF, cyc + 1);
        idle(3);

        // Abort in GET3 outranks a valid byte in the same cycle.
        put(8'h93, 1'b1);
        put(8'h01, 1'b0);
        put(8'h02, 1'b0);
        rx_abort = 1'b1;
        put(8'h03, 1'b0);
        rx_abort = 1'b0;
        push_err(cyc);
        idle(3);
        chk("hold_after_abort",
            {cmd_addr, cmd_data, cmd_count},
            {last_addr, last_data, exp_cnt});

        // Abort in IDLE blocks the sof; following bytes are ignored.
        rx_abort = 1'b1;
        put(8'h93, 1'b1);
        rx_abort = 1'b0;
        put(8'h01, 1'b0);
        put(8'h02, 1'b0);
        put(8'h03, 1'b0);
        put(8'h04, 1'b0);
        idle(3);

        // Watchdog: cmd_ptt holds for 99 edges after rqst, drops at 100.
        send_cmd(8'h01, 32'hCAFE0001, 0);
        repeat (100) @(posedge clk);
        #1;
        chk("wdog_before", {cmd_ptt, ptt_wdog}, 2'b10);
        @(posedge clk);
        #1;
        chk("wdog_expired", {cmd_ptt, ptt_wdog}, 2'b01);
        idle(10);
        chk("wdog_held", {cmd_ptt, ptt_wdog}, 2'b01);
        send_cmd(8'h01, 32'hCAFE0002, 0);
        idle(2);
        chk("wdog_restored", {cmd_ptt, ptt_wdog}, 2'b10);

        // Asynchronous reset in the middle of GET2.
        put(8'h93, 1'b1);
        put(8'h55, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset",
            {cmd_addr, cmd_data, cmd_rqst, cmd_requires_resp,
             cmd_ptt, cmd_err, ptt_wdog, cmd_count}, 0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_cnt = '0;
        put(8'h66, 1'b0);
        put(8'h77, 1'b0);
        idle(2);
        send_cmd(8'h93, 32'h12345678, 0);
        idle(2);

        // Fifteen more commands, mostly back-to-back, wrap count to 0.
        for (int i = 0; i < 15; i++) begin
            send_cmd(8'(8'h10 + i), 32'h01020300 + i, 0);
        end
        idle(3);
        chk("count_wrap", cmd_count, 4'd0);

        idle(30);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_event err=%0b cyc=%0d", e.is_err, e.cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
